// File: rtl/hazard_stall_controller_pkg.sv
// rtl/hazard_stall_controller_pkg.sv - shared constants, IR field positions, FSM encoding and decode helpers
// Contents:
//   opcode / ALU-op constants, IR field bit positions, multdiv FSM state type,
//   rstatus codes, and small decode functions used by the top and md_sequencer.
package hazard_stall_controller_pkg;

  localparam logic [4:0] OP_ALU = 5'b00000;
  localparam logic [4:0] OP_LW  = 5'b01000;
  localparam logic [4:0] OP_SW  = 5'b00111;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_BLT = 5'b00110;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 27;
  localparam int RD_HI    = 26;
  localparam int RD_LO    = 22;
  localparam int RS_HI    = 21;
  localparam int RS_LO    = 17;
  localparam int RT_HI    = 16;
  localparam int RT_LO    = 12;
  localparam int ALUOP_HI = 6;
  localparam int ALUOP_LO = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdState_e;

  // Value written to $r30 when a multdiv exception is taken
  localparam logic [31:0] RSTATUS_MUL = 32'd4;
  localparam logic [31:0] RSTATUS_DIV = 32'd5;

  function automatic logic isMul(input logic [4:0] opcode, input logic [4:0] aluOp);
    return (opcode == OP_ALU) && (aluOp == ALU_MUL);
  endfunction

  function automatic logic isDiv(input logic [4:0] opcode, input logic [4:0] aluOp);
    return (opcode == OP_ALU) && (aluOp == ALU_DIV);
  endfunction

  // sw and the branches read their rd field as a source operand
  function automatic logic readsRd(input logic [4:0] opcode);
    return (opcode == OP_SW) || (opcode == OP_BNE) || (opcode == OP_BLT);
  endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - pipeline-side bundle between the datapath and the hazard/stall controller
// Signals:
//   FD_IR, DX_IR                          instructions latched in FD and DX
//   md_result_rdy, md_exception, md_result multdiv unit result handshake
//   ctrl_MULT, ctrl_DIV                   one-cycle multdiv start pulses
//   stall_F, stall_D, stall_X             hold PC / FD / DX
//   bubble_DX, bubble_XM                  load nop into DX / XM
//   md_sel, md_result_q, md_exc, md_is_div latched multdiv result handed to XM
// Modports: master = datapath side, slave = controller side.
interface hazard_stall_controller_if;

  logic [31:0] FD_IR;
  logic [31:0] DX_IR;
  logic        md_result_rdy;
  logic        md_exception;
  logic [31:0] md_result;

  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        stall_F;
  logic        stall_D;
  logic        stall_X;
  logic        bubble_DX;
  logic        bubble_XM;
  logic        md_sel;
  logic [31:0] md_result_q;
  logic        md_exc;
  logic        md_is_div;

  modport master (
    output FD_IR, DX_IR, md_result_rdy, md_exception, md_result,
    input  ctrl_MULT, ctrl_DIV, stall_F, stall_D, stall_X, bubble_DX, bubble_XM,
    input  md_sel, md_result_q, md_exc, md_is_div
  );

  modport slave (
    input  FD_IR, DX_IR, md_result_rdy, md_exception, md_result,
    output ctrl_MULT, ctrl_DIV, stall_F, stall_D, stall_X, bubble_DX, bubble_XM,
    output md_sel, md_result_q, md_exc, md_is_div
  );

endinterface

// File: rtl/hazard_stall_controller_md_sequencer.sv
// rtl/hazard_stall_controller_md_sequencer.sv - multdiv start/busy/done FSM with timeout and result latches
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   dxIr                      instruction in DX (mul/div decode)
//   mdResultRdy, mdException, mdResult   multdiv unit result
//   ctrlMult, ctrlDiv         start pulses, only in the IDLE cycle that sees mul/div in DX
//   mdStall                   freeze PC/FD/DX and bubble XM (start cycle + BUSY)
//   mdSel                     high in DONE only
//   mdResultQ, mdExc, mdIsDiv latched result, exception and op type
module hazard_stall_controller_md_sequencer
  import hazard_stall_controller_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6   // 2**CNT_W must exceed MD_TIMEOUT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dxIr,
  input  logic        mdResultRdy,
  input  logic        mdException,
  input  logic [31:0] mdResult,
  output logic        ctrlMult,
  output logic        ctrlDiv,
  output logic        mdStall,
  output logic        mdSel,
  output logic [31:0] mdResultQ,
  output logic        mdExc,
  output logic        mdIsDiv
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MD_TIMEOUT - 1);

  mdState_e         state;
  logic [CNT_W-1:0] busyCnt;
  logic             dxMul;
  logic             dxDiv;
  logic             startNow;
  logic             unusedDxBits;

  assign dxMul = isMul(dxIr[OPC_HI:OPC_LO], dxIr[ALUOP_HI:ALUOP_LO]);
  assign dxDiv = isDiv(dxIr[OPC_HI:OPC_LO], dxIr[ALUOP_HI:ALUOP_LO]);
  assign unusedDxBits = ^{dxIr[RD_HI:ALUOP_HI+1], dxIr[ALUOP_LO-1:0]};

  // The start must stall DX in the same cycle it is decoded, so the pulses
  // and the start-cycle stall are taken from IDLE combinationally. Gating
  // with reset keeps a held reset from issuing a start the FSM never follows.
  assign ctrlMult = (state == IDLE) && dxMul && !reset;
  assign ctrlDiv  = (state == IDLE) && dxDiv && !reset;
  assign startNow = ctrlMult || ctrlDiv;
  assign mdStall  = startNow || (state == BUSY);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busyCnt   <= '0;
      mdSel     <= 1'b0;
      mdResultQ <= '0;
      mdExc     <= 1'b0;
      mdIsDiv   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mdSel <= 1'b0;
          if (startNow) begin
            state   <= BUSY;
            busyCnt <= '0;
            mdIsDiv <= ctrlDiv;
          end
        end
        BUSY: begin
          busyCnt <= busyCnt + 1'b1;
          // A result arriving on the timeout cycle is still a real result
          if (mdResultRdy) begin
            mdResultQ <= mdResult;
            mdExc     <= mdException;
            mdSel     <= 1'b1;
            state     <= DONE;
          end else if (busyCnt == TIMEOUT_LAST) begin
            mdResultQ <= '0;
            mdExc     <= 1'b1;
            mdSel     <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // DX still holds the finished mul/div here; never restart from DONE
          mdSel <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mdSel <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use and multdiv hazard stall/bubble controller for the 5-stage pipeline
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   bus    hazard_stall_controller_if.slave: FD/DX instructions and multdiv result in,
//          start pulses, stalls, bubbles and latched multdiv result out
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  hazard_stall_controller_if.slave  bus
);

  logic       mdStall;
  logic       loadUse;
  logic [4:0] dxRd;
  logic [4:0] fdOp;
  logic       unusedFdBits;

  hazard_stall_controller_md_sequencer #(
    .MD_TIMEOUT (MD_TIMEOUT),
    .CNT_W      (CNT_W)
  ) uSeq (
    .clock       (clock),
    .reset       (reset),
    .dxIr        (bus.DX_IR),
    .mdResultRdy (bus.md_result_rdy),
    .mdException (bus.md_exception),
    .mdResult    (bus.md_result),
    .ctrlMult    (bus.ctrl_MULT),
    .ctrlDiv     (bus.ctrl_DIV),
    .mdStall     (mdStall),
    .mdSel       (bus.md_sel),
    .mdResultQ   (bus.md_result_q),
    .mdExc       (bus.md_exc),
    .mdIsDiv     (bus.md_is_div)
  );

  assign dxRd = bus.DX_IR[RD_HI:RD_LO];
  assign fdOp = bus.FD_IR[OPC_HI:OPC_LO];
  assign unusedFdBits = ^bus.FD_IR[RT_LO-1:0];

  // A load into $0 never produces a value worth waiting for
  assign loadUse = (bus.DX_IR[OPC_HI:OPC_LO] == OP_LW) && (dxRd != 5'd0) &&
                   ((bus.FD_IR[RS_HI:RS_LO] == dxRd) ||
                    (bus.FD_IR[RT_HI:RT_LO] == dxRd) ||
                    (readsRd(fdOp) && (bus.FD_IR[RD_HI:RD_LO] == dxRd)));

  // While multdiv freezes DX the load stays put, so no DX bubble is needed
  assign bus.stall_F   = mdStall || loadUse;
  assign bus.stall_D   = mdStall || loadUse;
  assign bus.stall_X   = mdStall;
  assign bus.bubble_XM = mdStall;
  assign bus.bubble_DX = loadUse && !mdStall;

endmodule
